video_timing_gen: RTL and testbench

Pixel-clock raster timing generator that drives the DE, C0 (hsync) and C1 (vsync) inputs of the three TMDS encoder channels.
- Also supplies the pixel coordinates consumed by the pixel source.
- Defaults give 640x480@60 (25.175 MHz pixel clock).
- All outputs are registered and mutually coherent in the same cycle.

---
 rtl/vtg_pkg.sv | 42 ++++
 rtl/vtg_wrap_counter.sv | 33 +++
 rtl/video_timing_gen.sv | 150 +++++++++++++++
 tb/tb_video_timing_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// Shared types and constants for the video timing generator.
// The optional colour-bar helper is only used when VTG_PATTERN_EN is defined.
package vtg_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vtg_timing_t;

  localparam vtg_timing_t VTG_640x480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  // Which timing signal drives each TMDS encoder control input.
  typedef enum logic [1:0] {
    TMDS_CTL_ZERO,
    TMDS_CTL_HSYNC,
    TMDS_CTL_VSYNC
  } tmds_ctl_src_e;

  localparam tmds_ctl_src_e TMDS_BLUE_C0  = TMDS_CTL_HSYNC;
  localparam tmds_ctl_src_e TMDS_BLUE_C1  = TMDS_CTL_VSYNC;
  localparam tmds_ctl_src_e TMDS_GREEN_C0 = TMDS_CTL_ZERO;
  localparam tmds_ctl_src_e TMDS_GREEN_C1 = TMDS_CTL_ZERO;
  localparam tmds_ctl_src_e TMDS_RED_C0   = TMDS_CTL_ZERO;
  localparam tmds_ctl_src_e TMDS_RED_C1   = TMDS_CTL_ZERO;

  localparam int unsigned VTG_NUM_BARS = 8;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] vtg_bar_rgb(input logic [2:0] idx);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction

endpackage

// File: rtl/vtg_wrap_counter.sv
// Modulo counter that resets to its last value so the first enabled edge lands on 0.
// o_wrap is combinational: high when the next increment returns the count to 0.
module vtg_wrap_counter
  import vtg_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 16
) (
  input  logic         clk_i,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_wrap    = i_inc && w_at_last;
  assign o_count   = r_count;

  always_ff @(posedge clk_i) begin
    if (i_rst) begin
      r_count <= LAST;
    end else if (i_inc) begin
      r_count <= w_at_last ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered DE/hsync/vsync, pixel coordinates and start pulses.
// Define VTG_PATTERN_EN to add the rgb_o colour-bar test pattern output.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VTG_640x480.h_active,
  parameter int unsigned H_FP     = VTG_640x480.h_fp,
  parameter int unsigned H_SYNC   = VTG_640x480.h_sync,
  parameter int unsigned H_BP     = VTG_640x480.h_bp,
  parameter int unsigned V_ACTIVE = VTG_640x480.v_active,
  parameter int unsigned V_FP     = VTG_640x480.v_fp,
  parameter int unsigned V_SYNC   = VTG_640x480.v_sync,
  parameter int unsigned V_BP     = VTG_640x480.v_bp,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int W_X = $clog2(H_TOTAL),
  localparam int W_Y = $clog2(V_TOTAL)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [W_X-1:0] x_o,
  output logic [W_Y-1:0] y_o,
  output logic           line_start_o,
  output logic           frame_start_o
`ifdef VTG_PATTERN_EN
  ,
  output logic [23:0]    rgb_o
`endif
);

  if (H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL and V_TOTAL must both be at least 2");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
    $error("video_timing_gen: every timing parameter must be at least 1");
  end

  localparam logic [W_X-1:0] H_ACT_END  = W_X'(H_ACTIVE);
  localparam logic [W_X-1:0] H_SYNC_BEG = W_X'(H_ACTIVE + H_FP);
  localparam logic [W_X-1:0] H_SYNC_END = W_X'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [W_Y-1:0] V_ACT_END  = W_Y'(V_ACTIVE);
  localparam logic [W_Y-1:0] V_SYNC_BEG = W_Y'(V_ACTIVE + V_FP);
  localparam logic [W_Y-1:0] V_SYNC_END = W_Y'(V_ACTIVE + V_FP + V_SYNC);

  logic [W_X-1:0] w_h_cnt;
  logic [W_Y-1:0] w_v_cnt;
  logic           w_h_wrap;
  logic           w_v_wrap;

  vtg_wrap_counter #(.W(W_X), .MOD(int'(H_TOTAL))) u_h_cnt (
    .clk_i   (clk_i),
    .i_rst   (rst_i),
    .i_inc   (1'b1),
    .o_count (w_h_cnt),
    .o_wrap  (w_h_wrap)
  );

  vtg_wrap_counter #(.W(W_Y), .MOD(int'(V_TOTAL))) u_v_cnt (
    .clk_i   (clk_i),
    .i_rst   (rst_i),
    .i_inc   (w_h_wrap),
    .o_count (w_v_cnt),
    .o_wrap  (w_v_wrap)
  );

  // Decode the values the counters take at this edge so outputs line up with x/y.
  logic [W_X-1:0] w_h_next;
  logic [W_Y-1:0] w_v_next;
  logic           w_de_next;
  logic           w_hs_active;
  logic           w_vs_active;
  logic           w_line_next;
  logic           w_frame_next;

  assign w_h_next     = w_h_wrap ? '0 : w_h_cnt + W_X'(1);
  assign w_v_next     = w_v_wrap ? '0 : (w_h_wrap ? w_v_cnt + W_Y'(1) : w_v_cnt);
  assign w_de_next    = (w_h_next < H_ACT_END) && (w_v_next < V_ACT_END);
  assign w_hs_active  = (w_h_next >= H_SYNC_BEG) && (w_h_next < H_SYNC_END);
  assign w_vs_active  = (w_v_next >= V_SYNC_BEG) && (w_v_next < V_SYNC_END);
  assign w_line_next  = (w_h_next == '0);
  assign w_frame_next = w_line_next && (w_v_next == '0);

  logic           r_de;
  logic           r_hsync;
  logic           r_vsync;
  logic [W_X-1:0] r_x;
  logic [W_Y-1:0] r_y;
  logic           r_line_start;
  logic           r_frame_start;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_de          <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_de          <= w_de_next;
      r_hsync       <= w_hs_active ? H_POL : ~H_POL;
      r_vsync       <= w_vs_active ? V_POL : ~V_POL;
      r_x           <= w_h_next;
      r_y           <= w_v_next;
      r_line_start  <= w_line_next;
      r_frame_start <= w_frame_next;
    end
  end

  assign de_o          = r_de;
  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign x_o           = r_x;
  assign y_o           = r_y;
  assign line_start_o  = r_line_start;
  assign frame_start_o = r_frame_start;

`ifdef VTG_PATTERN_EN
  // Bars are H_ACTIVE/8 wide; anything past the seventh boundary is the last bar.
  localparam int unsigned BAR_W = H_ACTIVE / VTG_NUM_BARS;

  logic [2:0]  w_bar_idx;
  logic [23:0] r_rgb;

  always_comb begin
    w_bar_idx = '0;
    for (int k = 1; k < int'(VTG_NUM_BARS); k++) begin
      if (w_h_next >= W_X'(k * int'(BAR_W))) w_bar_idx = 3'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_de_next ? vtg_bar_rgb(w_bar_idx) : 24'h000000;
    end
  end

  assign rgb_o = r_rgb;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 timing plus two reduced rasters for frame-level checks.
// Colour-bar checks are compiled in when VTG_PATTERN_EN is defined.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1, rst_m = 1'b1, rst_s = 1'b1;

  logic d_de, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic m_de, m_hs, m_vs, m_ls, m_fs;
  logic [3:0] m_x, m_y;
  logic s_de, s_hs, s_vs, s_ls, s_fs;
  logic [2:0] s_x, s_y;
`ifdef VTG_PATTERN_EN
  logic [23:0] d_rgb, m_rgb, s_rgb;
`endif

  int errors = 0;
  int checks = 0;

  video_timing_gen u_dut_d (
    .clk_i(clk), .rst_i(rst_d), .de_o(d_de), .hsync_o(d_hs), .vsync_o(d_vs),
    .x_o(d_x), .y_o(d_y), .line_start_o(d_ls), .frame_start_o(d_fs)
`ifdef VTG_PATTERN_EN
    , .rgb_o(d_rgb)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_dut_m (
    .clk_i(clk), .rst_i(rst_m), .de_o(m_de), .hsync_o(m_hs), .vsync_o(m_vs),
    .x_o(m_x), .y_o(m_y), .line_start_o(m_ls), .frame_start_o(m_fs)
`ifdef VTG_PATTERN_EN
    , .rgb_o(m_rgb)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut_s (
    .clk_i(clk), .rst_i(rst_s), .de_o(s_de), .hsync_o(s_hs), .vsync_o(s_vs),
    .x_o(s_x), .y_o(s_y), .line_start_o(s_ls), .frame_start_o(s_fs)
`ifdef VTG_PATTERN_EN
    , .rgb_o(s_rgb)
`endif
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({d_de, d_hs, d_vs, d_ls, d_fs, d_x, d_y} !== {5'b01100, 10'd0, 10'd0}) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 01100 x=0 y=0",
                 i, {d_de, d_hs, d_vs, d_ls, d_fs}, d_x, d_y);
      end
    end
    rst_d = 1'b0;
    step();
    checks++;
    if ({d_de, d_hs, d_vs, d_ls, d_fs, d_x, d_y} !== {5'b11111, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_release got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 11111 x=0 y=0",
               {d_de, d_hs, d_vs, d_ls, d_fs}, d_x, d_y);
    end
  endtask

  // Starts at (0,0) of the default raster, ends at (0,1).
  task automatic test_line();
    int bad = 0, first_bad = -1, hs_low = 0, de_hi = 0;
    logic exp_de, exp_hs;
    for (int i = 0; i < 800; i++) begin
      exp_de = (i < 640);
      exp_hs = !(i >= 656 && i < 752);
      if ({d_de, d_hs, d_vs, d_ls, d_fs} !== {exp_de, exp_hs, 1'b1, i == 0, i == 0} ||
          d_x !== 10'(i) || d_y !== 10'd0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (d_hs === 1'b0) hs_low++;
      if (d_de === 1'b1) de_hi++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL line_decode bad_cycles=%0d first_x=%0d exp 0", bad, first_bad);
    end
    checks++;
    if (hs_low !== 96) begin
      errors++;
      $display("FAIL line_hsync_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (de_hi !== 640) begin
      errors++;
      $display("FAIL line_de_width got=%0d exp=640", de_hi);
    end
    checks++;
    if ({d_x, d_y, d_ls, d_fs} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL line_period got x=%0d y=%0d ls=%b fs=%b exp x=0 y=1 ls=1 fs=0",
               d_x, d_y, d_ls, d_fs);
    end
  endtask

  task automatic test_mid_reset();
    repeat (300) step();
    checks++;
    if (d_x !== 10'd300 || d_y !== 10'd1) begin
      errors++;
      $display("FAIL midrst_position got x=%0d y=%0d exp x=300 y=1", d_x, d_y);
    end
    rst_d = 1'b1;
    step();
    checks++;
    if ({d_de, d_hs, d_vs, d_ls, d_fs, d_x, d_y} !== {5'b01100, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL midrst_reset got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 01100 x=0 y=0",
               {d_de, d_hs, d_vs, d_ls, d_fs}, d_x, d_y);
    end
    rst_d = 1'b0;
    step();
    checks++;
    if ({d_de, d_hs, d_vs, d_ls, d_fs, d_x, d_y} !== {5'b11111, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL midrst_restart got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 11111 x=0 y=0",
               {d_de, d_hs, d_vs, d_ls, d_fs}, d_x, d_y);
    end
  endtask

  // 16x12 raster, active-low syncs: hsync x 10..12, vsync y 8..9, 192 cycles per frame.
  task automatic test_frames();
    int bad = 0, first_bad = -1, fs_cnt = 0, last_fs = -1, bad_period = 0;
    int vs_low = 0, vs_misalign = 0, de_hi = 0;
    int x, y;
    logic prev_vs;
    logic exp_de, exp_hs, exp_vs;
    rst_m = 1'b1;
    step();
    rst_m = 1'b0;
    step();
    prev_vs = m_vs;
    for (int c = 0; c <= 384; c++) begin
      x = c % 16;
      y = (c / 16) % 12;
      exp_de = (x < 8) && (y < 6);
      exp_hs = !(x >= 10 && x < 13);
      exp_vs = !(y >= 8 && y < 10);
      if ({m_de, m_hs, m_vs, m_ls, m_fs} !== {exp_de, exp_hs, exp_vs, x == 0, x == 0 && y == 0} ||
          m_x !== 4'(x) || m_y !== 4'(y)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (m_fs === 1'b1) begin
        if (last_fs >= 0 && c - last_fs != 192) bad_period++;
        last_fs = c;
        fs_cnt++;
      end
      if (c < 384) begin
        if (m_vs === 1'b0) vs_low++;
        if (m_de === 1'b1) de_hi++;
      end
      if (m_vs !== prev_vs && x != 0) vs_misalign++;
      prev_vs = m_vs;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL frame_decode bad_cycles=%0d first_cycle=%0d exp 0", bad, first_bad);
    end
    checks++;
    if (fs_cnt !== 3 || bad_period !== 0) begin
      errors++;
      $display("FAIL frame_start_period got pulses=%0d bad_periods=%0d exp pulses=3 bad_periods=0",
               fs_cnt, bad_period);
    end
    checks++;
    if (vs_low !== 64) begin
      errors++;
      $display("FAIL frame_vsync_width got=%0d exp=64", vs_low);
    end
    checks++;
    if (vs_misalign !== 0) begin
      errors++;
      $display("FAIL frame_vsync_align got=%0d exp=0", vs_misalign);
    end
    checks++;
    if (de_hi !== 96) begin
      errors++;
      $display("FAIL frame_de_count got=%0d exp=96", de_hi);
    end
  endtask

  // 8x6 raster, active-high syncs: hsync x 5..6, vsync y 4, wrap at x=7 / y=5.
  task automatic test_small();
    int bad = 0, first_bad = -1;
    int x, y;
    rst_s = 1'b1;
    step();
    checks++;
    if ({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y} !== {5'b00000, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL small_reset got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 00000 x=0 y=0",
               {s_de, s_hs, s_vs, s_ls, s_fs}, s_x, s_y);
    end
    rst_s = 1'b0;
    step();
    for (int c = 0; c < 48; c++) begin
      x = c % 8;
      y = c / 8;
      if ({s_de, s_hs, s_vs, s_ls, s_fs} !==
          {(x < 4) && (y < 3), x >= 5 && x < 7, y == 4, x == 0, x == 0 && y == 0} ||
          s_x !== 3'(x) || s_y !== 3'(y)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (c == 47) begin
        checks++;
        if ({s_x, s_y} !== {3'd7, 3'd5}) begin
          errors++;
          $display("FAIL small_last got x=%0d y=%0d exp x=7 y=5", s_x, s_y);
        end
      end
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL small_decode bad_cycles=%0d first_cycle=%0d exp 0", bad, first_bad);
    end
    checks++;
    if ({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y} !== {5'b10011, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL small_wrap got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 10011 x=0 y=0",
               {s_de, s_hs, s_vs, s_ls, s_fs}, s_x, s_y);
    end
    repeat (19) step();
    rst_s = 1'b1;
    step();
    checks++;
    if ({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y} !== {5'b00000, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL small_midrst got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 00000 x=0 y=0",
               {s_de, s_hs, s_vs, s_ls, s_fs}, s_x, s_y);
    end
    rst_s = 1'b0;
    step();
    checks++;
    if ({s_de, s_hs, s_vs, s_ls, s_fs, s_x, s_y} !== {5'b10011, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL small_restart got de/hs/vs/ls/fs=%b x=%0d y=%0d exp 10011 x=0 y=0",
               {s_de, s_hs, s_vs, s_ls, s_fs}, s_x, s_y);
    end
  endtask

`ifdef VTG_PATTERN_EN
  task automatic test_pattern();
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [23:0] exp_rgb;
    int bad = 0, first_bad = -1, b;
    rst_d = 1'b1;
    step();
    checks++;
    if (d_rgb !== 24'h000000) begin
      errors++;
      $display("FAIL pattern_reset got=%h exp=000000", d_rgb);
    end
    rst_d = 1'b0;
    step();
    for (int i = 0; i < 800; i++) begin
      b = (i / 80 > 7) ? 7 : i / 80;
      exp_rgb = (i < 640) ? bars[b] : 24'h000000;
      if (d_rgb !== exp_rgb) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i == 0 || i == 80 || i == 639 || i == 700) begin
        checks++;
        if (d_rgb !== exp_rgb) begin
          errors++;
          $display("FAIL pattern_x%0d got=%h exp=%h", i, d_rgb, exp_rgb);
        end
      end
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pattern_line bad_cycles=%0d first_x=%0d exp 0", bad, first_bad);
    end
  endtask
`endif

  initial begin
    rst_d = 1'b1;
    rst_m = 1'b1;
    rst_s = 1'b1;
    @(negedge clk);
    test_reset();
    test_line();
    test_mid_reset();
    test_frames();
    test_small();
`ifdef VTG_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
